param_traf_cont: RTL and testbench

PARAM_TRAF_CONT -- requirements
Module: param_traf_cont

---
 rtl/traf_pkg.sv | 22 ++
 rtl/traf_timer.sv | 24 ++
 rtl/param_traf_cont.sv | 129 ++++++++++++
 tb/tb_param_traf_cont.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traf_pkg.sv
// Shared definitions for the parameterised traffic-light controller:
// lamp encodings and the controller state enum.
package traf_pkg;

   localparam logic [1:0] RED    = 2'd0;
   localparam logic [1:0] YELLOW = 2'd1;
   localparam logic [1:0] GREEN  = 2'd2;

   typedef enum logic [2:0] {
      HGRN  = 3'd0,
      HYEL  = 3'd1,
      ARED1 = 3'd2,
      CGRN  = 3'd3,
      CYEL  = 3'd4,
      ARED2 = 3'd5
`ifdef TRAF_PED_EN
      ,
      WALK  = 3'd6
`endif
   } state_e;

endpackage

// File: rtl/traf_timer.sv
// Phase timer: clears on load (or reset), otherwise counts up and
// saturates at all-ones so it never wraps.
// Ports: i_clk, i_clear_n (sync active-low), i_load, o_cnt[CNT_W].
module traf_timer #(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_clear_n,
   input  logic             i_load,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_clear_n || i_load)
         r_cnt <= '0;
      else if (r_cnt != '1)
         r_cnt <= r_cnt + 1'b1;
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/param_traf_cont.sv
// Highway/country traffic-light controller with cycle-count phase timing.
// Ports: clock, clear_n (sync active-low), X (country sensor),
//   hghwy[2], cntry[2] lamp codes; ped_req/walk only with TRAF_PED_EN.
module param_traf_cont
   import traf_pkg::*;
#(
   parameter int CNT_W      = 8,
   parameter int MIN_HGRN   = 4,
   parameter int Y2R_DELAY  = 3,
   parameter int R2G_DELAY  = 2,
   parameter int MAX_CGRN   = 10,
   parameter int WALK_DELAY = 5
) (
   input  logic       clock,
   input  logic       clear_n,
   input  logic       X,
   output logic [1:0] hghwy,
   output logic [1:0] cntry
`ifdef TRAF_PED_EN
   ,
   input  logic       ped_req,
   output logic       walk
`endif
);

   localparam longint P_MAX = (longint'(1) << CNT_W) - 1;

   if (MIN_HGRN < 1 || MIN_HGRN > P_MAX ||
       Y2R_DELAY < 1 || Y2R_DELAY > P_MAX ||
       R2G_DELAY < 1 || R2G_DELAY > P_MAX ||
       MAX_CGRN < 1 || MAX_CGRN > P_MAX ||
       WALK_DELAY < 1 || WALK_DELAY > P_MAX) begin : g_param_chk
      $error("param_traf_cont: delay parameter out of range");
   end

   // Timer reads N-1 during the Nth cycle of a phase.
   localparam logic [CNT_W-1:0] L_HG  = CNT_W'(MIN_HGRN - 1);
   localparam logic [CNT_W-1:0] L_Y2R = CNT_W'(Y2R_DELAY - 1);
   localparam logic [CNT_W-1:0] L_R2G = CNT_W'(R2G_DELAY - 1);
   localparam logic [CNT_W-1:0] L_CG  = CNT_W'(MAX_CGRN - 1);

   state_e           r_state;
   state_e           w_next;
   logic [CNT_W-1:0] w_tmr;
   logic             w_load;
   logic             w_hreq;

`ifdef TRAF_PED_EN
   localparam logic [CNT_W-1:0] L_WK = CNT_W'(WALK_DELAY - 1);

   logic r_pend;

   // A request arriving on the WALK-entry edge wins over the clear.
   always_ff @(posedge clock) begin
      if (!clear_n)
         r_pend <= 1'b0;
      else if (ped_req)
         r_pend <= 1'b1;
      else if (w_next == WALK && r_state != WALK)
         r_pend <= 1'b0;
   end

   assign w_hreq = X || r_pend;
`else
   assign w_hreq = X;
`endif

   always_ff @(posedge clock) begin
      if (!clear_n)
         r_state <= HGRN;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         HGRN:  if (w_tmr >= L_HG && w_hreq) w_next = HYEL;
         HYEL:  if (w_tmr >= L_Y2R) w_next = ARED1;
         ARED1: begin
            if (w_tmr >= L_R2G) begin
`ifdef TRAF_PED_EN
               w_next = r_pend ? WALK : CGRN;
`else
               w_next = CGRN;
`endif
            end
         end
         CGRN:  if (!X || w_tmr >= L_CG) w_next = CYEL;
         CYEL:  if (w_tmr >= L_Y2R) w_next = ARED2;
         ARED2: if (w_tmr >= L_R2G) w_next = HGRN;
`ifdef TRAF_PED_EN
         WALK:  if (w_tmr >= L_WK) w_next = X ? CGRN : ARED2;
`endif
         default: w_next = HGRN;
      endcase
   end

   assign w_load = (w_next != r_state);

   traf_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .i_clk    (clock),
      .i_clear_n(clear_n),
      .i_load   (w_load),
      .o_cnt    (w_tmr)
   );

   always_comb begin
      hghwy = RED;
      cntry = RED;
      case (r_state)
         HGRN: hghwy = GREEN;
         HYEL: hghwy = YELLOW;
         CGRN: cntry = GREEN;
         CYEL: cntry = YELLOW;
         default: ;
      endcase
   end

`ifdef TRAF_PED_EN
   always_comb begin
      walk = 1'b0;
      if (r_state == WALK) walk = 1'b1;
   end
`endif

endmodule

// File: tb/tb_param_traf_cont.sv
// Self-checking bench for param_traf_cont: directed scenarios plus
// randomized traffic against a phase/elapsed-cycle reference model.
module tb_param_traf_cont;

   localparam int MIN_HGRN = 4;
   localparam int Y2R      = 3;
   localparam int R2G      = 2;
   localparam int MAX_CG   = 10;
   localparam int WALK_D   = 5;

   localparam int HG = 0, HY = 1, AR1 = 2, CG = 3, CY = 4, AR2 = 5, WK = 6;

   // {walk, hghwy, cntry}
   localparam logic [4:0] P_HG = 5'b0_10_00;
   localparam logic [4:0] P_HY = 5'b0_01_00;
   localparam logic [4:0] P_RR = 5'b0_00_00;
   localparam logic [4:0] P_CG = 5'b0_00_10;
   localparam logic [4:0] P_CY = 5'b0_00_01;
   localparam logic [4:0] P_WK = 5'b1_00_00;

   logic       clock   = 1'b0;
   logic       clear_n = 1'b0;
   logic       X       = 1'b0;
   logic [1:0] hghwy;
   logic [1:0] cntry;
   logic       walk_o;
   logic [4:0] obs;

   int checks   = 0;
   int failures = 0;

   int m_ph;
   int m_el;
   bit m_pend;

   int         run_len[$];
   logic [4:0] run_pat[$];

`ifdef TRAF_PED_EN
   logic ped_req = 1'b0;
   logic walk;
   assign walk_o = walk;
`else
   assign walk_o = 1'b0;
`endif

   assign obs = {walk_o, hghwy, cntry};

   param_traf_cont dut (
      .clock  (clock),
      .clear_n(clear_n),
      .X      (X),
      .hghwy  (hghwy),
      .cntry  (cntry)
`ifdef TRAF_PED_EN
      ,
      .ped_req(ped_req),
      .walk   (walk)
`endif
   );

   initial forever #5 clock = ~clock;

   function automatic logic [4:0] exp_pat();
      case (m_ph)
         HG: return P_HG;
         HY: return P_HY;
         CG: return P_CG;
         CY: return P_CY;
         WK: return P_WK;
         default: return P_RR;
      endcase
   endfunction

   // Phase rules: each phase has a required cycle count; m_el is the
   // number of cycles already spent in the current phase.
   task automatic model_step(input bit x, input bit pr, input bit rst);
      int nxt;
      if (rst) begin
         m_ph = HG; m_el = 1; m_pend = 0;
         return;
      end
      nxt = m_ph;
      case (m_ph)
         HG:  if (m_el >= MIN_HGRN && (x || m_pend)) nxt = HY;
         HY:  if (m_el >= Y2R) nxt = AR1;
         AR1: if (m_el >= R2G) nxt = m_pend ? WK : CG;
         CG:  if (!x || m_el >= MAX_CG) nxt = CY;
         CY:  if (m_el >= Y2R) nxt = AR2;
         AR2: if (m_el >= R2G) nxt = HG;
         WK:  if (m_el >= WALK_D) nxt = x ? CG : AR2;
         default: nxt = HG;
      endcase
      if (pr) m_pend = 1;
      else if (nxt == WK && m_ph != WK) m_pend = 0;
      m_el = (nxt != m_ph) ? 1 : m_el + 1;
      m_ph = nxt;
   endtask

   task automatic tick(input bit x, input bit pr, input bit rst);
      X = x;
      clear_n = !rst;
`ifdef TRAF_PED_EN
      ped_req = pr;
`endif
      @(posedge clock);
      #1;
`ifdef TRAF_PED_EN
      model_step(x, pr, rst);
`else
      model_step(x, 1'b0, rst);
`endif
      if (rst) begin
         run_len.delete();
         run_pat.delete();
      end
      if (run_pat.size() != 0 && run_pat[$] == obs)
         run_len[$] = run_len[$] + 1;
      else begin
         run_pat.push_back(obs);
         run_len.push_back(1);
      end
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b0, 1'b1);
      checks++;
      if (obs !== P_HG) begin
         failures++;
         $display("FAIL reset_init got=%b exp=%b", obs, P_HG);
      end
      for (int i = 0; i < 40 && m_ph != CY; i++) begin
         tick(1'b1, 1'b0, 1'b0);
         checks++;
         if (obs !== exp_pat()) begin
            failures++;
            $display("FAIL reset_run i=%0d got=%b exp=%b", i, obs, exp_pat());
         end
      end
      checks++;
      if (obs !== P_CY) begin
         failures++;
         $display("FAIL reset_reach_cyel got=%b exp=%b", obs, P_CY);
      end
      tick(1'b1, 1'b0, 1'b1);
      checks++;
      if (obs !== P_HG) begin
         failures++;
         $display("FAIL reset_in_cyel got=%b exp=%b", obs, P_HG);
      end
   endtask

   task automatic test_nominal();
      int         el[6];
      logic [4:0] ep[6];
      el = '{4, 3, 2, 3, 3, 2};
      ep = '{P_HG, P_HY, P_RR, P_CG, P_CY, P_RR};
      tick(1'b0, 1'b0, 1'b1);
      for (int t = 1; t <= 25; t++) begin
         tick(t <= 11, 1'b0, 1'b0);
         checks++;
         if (obs !== exp_pat()) begin
            failures++;
            $display("FAIL nominal t=%0d got=%b exp=%b", t, obs, exp_pat());
         end
      end
      checks++;
      if (run_len.size() < 7) begin
         failures++;
         $display("FAIL nominal_runs got=%0d exp>=7", run_len.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (run_pat[i] !== ep[i] || run_len[i] != el[i]) begin
               failures++;
               $display("FAIL nominal_phase i=%0d got=%b/%0d exp=%b/%0d",
                        i, run_pat[i], run_len[i], ep[i], el[i]);
            end
         end
      end
   endtask

   task automatic test_min_green();
      tick(1'b0, 1'b0, 1'b1);
      for (int t = 1; t <= 12; t++) begin
         tick(t == 2, 1'b0, 1'b0);
         checks++;
         if (obs !== P_HG || obs !== exp_pat()) begin
            failures++;
            $display("FAIL min_green_hold t=%0d got=%b exp=%b", t, obs, P_HG);
         end
      end
      tick(1'b0, 1'b0, 1'b1);
      for (int t = 1; t <= 5; t++) begin
         tick(t == 4, 1'b0, 1'b0);
         checks++;
         if (obs !== exp_pat()) begin
            failures++;
            $display("FAIL min_green t=%0d got=%b exp=%b", t, obs, exp_pat());
         end
      end
      checks++;
      if (run_len.size() < 2 || run_len[0] != 4 || run_pat[1] !== P_HY) begin
         failures++;
         $display("FAIL min_green_len got=%0d exp=4", run_len[0]);
      end
   endtask

   task automatic test_timeout();
      tick(1'b1, 1'b0, 1'b1);
      for (int t = 1; t <= 30; t++) begin
         tick(1'b1, 1'b0, 1'b0);
         checks++;
         if (obs !== exp_pat()) begin
            failures++;
            $display("FAIL timeout t=%0d got=%b exp=%b", t, obs, exp_pat());
         end
      end
      checks++;
      if (run_len.size() < 6 || run_pat[3] !== P_CG || run_len[3] != MAX_CG ||
          run_pat[4] !== P_CY) begin
         failures++;
         $display("FAIL timeout_cgrn got=%0d exp=%0d", run_len[3], MAX_CG);
      end
   endtask

   task automatic test_ared1_drop();
      tick(1'b1, 1'b0, 1'b1);
      for (int t = 1; t <= 20; t++) begin
         tick(t <= 7, 1'b0, 1'b0);
         checks++;
         if (obs !== exp_pat()) begin
            failures++;
            $display("FAIL ared1_drop t=%0d got=%b exp=%b", t, obs, exp_pat());
         end
      end
      checks++;
      if (run_len.size() < 6 || run_pat[3] !== P_CG || run_len[3] != 1 ||
          run_pat[4] !== P_CY || run_len[4] != Y2R) begin
         failures++;
         $display("FAIL ared1_drop_cgrn got=%0d exp=1", run_len[3]);
      end
   endtask

`ifdef TRAF_PED_EN
   task automatic test_ped();
      int         el[6];
      logic [4:0] ep[6];
      el = '{4, 3, 2, 5, 2, 1};
      ep = '{P_HG, P_HY, P_RR, P_WK, P_RR, P_HG};
      tick(1'b0, 1'b0, 1'b1);
      for (int t = 1; t <= 20; t++) begin
         tick(1'b0, t == 1, 1'b0);
         checks++;
         if (obs !== exp_pat()) begin
            failures++;
            $display("FAIL ped t=%0d got=%b exp=%b", t, obs, exp_pat());
         end
      end
      checks++;
      if (run_len.size() != 6) begin
         failures++;
         $display("FAIL ped_runs got=%0d exp=6", run_len.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (run_pat[i] !== ep[i] || run_len[i] != el[i]) begin
               failures++;
               $display("FAIL ped_phase i=%0d got=%b/%0d exp=%b/%0d",
                        i, run_pat[i], run_len[i], ep[i], el[i]);
            end
         end
      end
   endtask
`endif

   task automatic test_random();
      bit x;
      bit pr;
      bit rst;
      int mode;
      tick(1'b0, 1'b0, 1'b1);
      mode = 0;
      x = 0;
      for (int t = 0; t < 1500; t++) begin
         if ($urandom_range(0, 29) == 0) mode = $urandom_range(0, 2);
         case (mode)
            0: x = ($urandom_range(0, 3) != 0);
            1: x = ($urandom_range(0, 3) == 0);
            default: if ($urandom_range(0, 7) == 0) x = !x;
         endcase
         pr  = ($urandom_range(0, 24) == 0);
         rst = ($urandom_range(0, 149) == 0);
         tick(x, pr, rst);
         checks++;
         if (obs !== exp_pat()) begin
            failures++;
            $display("FAIL random t=%0d got=%b exp=%b", t, obs, exp_pat());
         end
      end
   endtask

   initial begin
      m_ph = HG; m_el = 1; m_pend = 0;
      repeat (2) @(posedge clock);
      #1;
      test_reset();
      test_nominal();
      test_min_green();
      test_timeout();
      test_ared1_drop();
`ifdef TRAF_PED_EN
      test_ped();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
